// File: rtl/seg_scan_driver_pkg.sv
// Shared glyph codes and active-low segment patterns for the seven-segment display path.
package seg_pkg;

    localparam logic [3:0] GLYPH_DASH  = 4'hA;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Segment order {a,b,c,d,e,f,g}, 0 = segment lit
    localparam logic [6:0] SEG_0     = 7'b000_0001;
    localparam logic [6:0] SEG_1     = 7'b100_1111;
    localparam logic [6:0] SEG_2     = 7'b001_0010;
    localparam logic [6:0] SEG_3     = 7'b000_0110;
    localparam logic [6:0] SEG_4     = 7'b100_1100;
    localparam logic [6:0] SEG_5     = 7'b010_0100;
    localparam logic [6:0] SEG_6     = 7'b010_0000;
    localparam logic [6:0] SEG_7     = 7'b000_1111;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b000_0100;
    localparam logic [6:0] SEG_DASH  = 7'b111_1110;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    function automatic logic [7:0] seg_with_dp(input logic [6:0] segs, input logic dp_lit);
        return {segs, ~dp_lit};
    endfunction

endpackage

// File: rtl/seg_scan_driver_glyph.sv
// Combinational glyph decoder: 4-bit digit code to active-low a..g segments.
module seg_glyph
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (code_i)
                4'd0:       seg_o = SEG_0;
                4'd1:       seg_o = SEG_1;
                4'd2:       seg_o = SEG_2;
                4'd3:       seg_o = SEG_3;
                4'd4:       seg_o = SEG_4;
                4'd5:       seg_o = SEG_5;
                4'd6:       seg_o = SEG_6;
                4'd7:       seg_o = SEG_7;
                4'd8:       seg_o = SEG_8;
                4'd9:       seg_o = SEG_9;
                GLYPH_DASH: seg_o = SEG_DASH;
                default:    seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver with frame-synchronous double-buffered updates.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int unsigned TW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_v_q, pend_v_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick_wrap;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              slot_code;
    logic                    slot_dp;
    logic                    slot_blank;
    logic [6:0]              glyph_seg;

    assign tick_wrap = enable && (tick_q == TICK_LAST);
    assign frame_end = tick_wrap && (idx_q == IDX_LAST);

    // Digit k is a leading zero when it and every digit above it are code 0
    always_comb begin
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
            run        = run & (disp_q[4*k +: 4] == 4'h0);
            lz_mask[k] = run & (LZ_BLANK != 0);
        end
    end

    always_comb begin
        slot_code  = GLYPH_BLANK;
        slot_dp    = 1'b0;
        slot_blank = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                slot_code  = disp_q[4*k +: 4];
                slot_dp    = disp_dp_q[k];
                slot_blank = lz_mask[k];
            end
        end
    end

    seg_glyph u_glyph (
        .code_i  (slot_code),
        .blank_i (slot_blank),
        .seg_o   (glyph_seg)
    );

    always_comb begin
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pend_v_d  = pend_v_q;
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        tick_d    = tick_q;
        idx_d     = idx_q;

        if (enable) begin
            if (tick_wrap) begin
                tick_d = '0;
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        // A load coinciding with the boundary bypasses pend and goes straight to disp
        if (frame_end) begin
            if (load) begin
                disp_d    = digits_in;
                disp_dp_d = dp_in;
            end else if (pend_v_q) begin
                disp_d    = pend_q;
                disp_dp_d = pend_dp_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d    = digits_in;
            pend_dp_d = dp_in;
            pend_v_d  = 1'b1;
        end
    end

    always_comb begin
        an_d         = '1;
        seg_d        = 8'hFF;
        frame_done_d = frame_end;
        if (enable) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                an_d[k] = (idx_q != IW'(k));
            end
            seg_d = seg_with_dp(glyph_seg, slot_dp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_v_q     <= 1'b0;
            disp_q       <= '1;
            disp_dp_q    <= '0;
            tick_q       <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_v_q     <= pend_v_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with 4 digits and 4 cycles per slot.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    seg_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .LZ_BLANK    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [7:0]  exp_seg [4];
    } vec_t;

    exp_t sbq[$];

    // Reference model: position within the frame counted in enabled cycles
    int unsigned m_pos;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_pdp, m_ddp;
    logic        m_pv;

    function automatic logic [7:0] render(input logic [15:0] d, input logic [3:0] dp,
                                          input int unsigned s);
        logic [6:0] g;
        logic [3:0] c;
        int         hi;
        hi = -1;
        for (int k = 0; k < 4; k++)
            if (d[4*k +: 4] != 4'h0) hi = k;
        c = d[4*s +: 4];
        case (c)
            4'd0: g = 7'b0000001;
            4'd1: g = 7'b1001111;
            4'd2: g = 7'b0010010;
            4'd3: g = 7'b0000110;
            4'd4: g = 7'b1001100;
            4'd5: g = 7'b0100100;
            4'd6: g = 7'b0100000;
            4'd7: g = 7'b0001111;
            4'd8: g = 7'b0000000;
            4'd9: g = 7'b0000100;
            4'hA: g = 7'b1111110;
            default: g = 7'b1111111;
        endcase
        if (s > 0 && int'(s) > hi) g = 7'b1111111;
        return {g, ~dp[s]};
    endfunction

    task automatic cycle();
        exp_t        e;
        exp_t        got;
        int unsigned slot;
        if (rst) begin
            e      = '{an: 4'hF, seg: 8'hFF, fd: 1'b0};
            m_pos  = 0;
            m_pv   = 1'b0;
            m_pend = 16'h0;
            m_pdp  = 4'h0;
            m_disp = 16'hFFFF;
            m_ddp  = 4'h0;
        end else if (enable) begin
            slot  = m_pos / 4;
            e.an  = ~(4'(1) << slot);
            e.seg = render(m_disp, m_ddp, slot);
            e.fd  = (m_pos == 15);
            if (m_pos == 15) begin
                if (load) begin
                    m_disp = digits_in;
                    m_ddp  = dp_in;
                end else if (m_pv) begin
                    m_disp = m_pend;
                    m_ddp  = m_pdp;
                end
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = digits_in;
                m_pdp  = dp_in;
                m_pv   = 1'b1;
            end
            m_pos = (m_pos + 1) % 16;
        end else begin
            e = '{an: 4'hF, seg: 8'hFF, fd: 1'b0};
            if (load) begin
                m_pend = digits_in;
                m_pdp  = dp_in;
                m_pv   = 1'b1;
            end
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e   = sbq.pop_front();
        got = '{an: an, seg: seg, fd: frame_done};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL sb cyc=%0d an=%b want %b seg=%b want %b fd=%b want %b",
                     cyc, got.an, e.an, got.seg, e.seg, got.fd, e.fd);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_fd(input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (frame_done !== 1'b1 && n < 40);
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout waiting for frame_done got=%b want=1", name, frame_done);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int slot;
        digits_in = v.d;
        dp_in     = v.dp;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        wait_fd($sformatf("vec%0d", id));
        for (int i = 0; i < 16; i++) begin
            cycle();
            case (an)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b0111: slot = 3;
                default: slot = -1;
            endcase
            total++;
            if (slot < 0) begin
                bad++;
                $display("FAIL vec%0d_an got=%b want one-hot-low", id, an);
            end else if (seg !== v.exp_seg[slot]) begin
                bad++;
                $display("FAIL vec%0d_seg slot=%0d got=%b want=%b", id, slot, seg, v.exp_seg[slot]);
            end
        end
    endtask

    task automatic wait_pos(input int unsigned p);
        int n;
        n = 0;
        while (m_pos != p && n < 32) begin
            cycle();
            n++;
        end
        total++;
        if (m_pos != p) begin
            bad++;
            $display("FAIL wait_pos got=%0d want=%0d", m_pos, p);
        end
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{d: 16'h1234, dp: 4'b0100,
                    exp_seg: '{8'b1001_1001, 8'b0000_1101, 8'b0010_0100, 8'b1001_1111}};
        vecs[1] = '{d: 16'h0070, dp: 4'b0000,
                    exp_seg: '{8'b0000_0011, 8'b0001_1111, 8'hFF, 8'hFF}};
        vecs[2] = '{d: 16'h0000, dp: 4'b0000,
                    exp_seg: '{8'b0000_0011, 8'hFF, 8'hFF, 8'hFF}};
        vecs[3] = '{d: 16'hA00F, dp: 4'b0010,
                    exp_seg: '{8'hFF, 8'b0000_0010, 8'b0000_0011, 8'b1111_1101}};
        vecs[4] = '{d: 16'h0005, dp: 4'b1000,
                    exp_seg: '{8'b0100_1001, 8'hFF, 8'hFF, 8'b1111_1110}};
        vecs[5] = '{d: 16'h8960, dp: 4'b0001,
                    exp_seg: '{8'b0000_0010, 8'b0100_0001, 8'b0000_1001, 8'b0000_0001}};

        rst       = 1'b1;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0;
        dp_in     = 4'h0;
        run(3);
        rst    = 1'b0;
        enable = 1'b1;

        // Free-running scan of a blank display
        run(36);

        // Glyph, decimal point and leading-zero cases
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Last load before the boundary wins
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(3);
        digits_in = 16'hA005;
        dp_in     = 4'h0;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        wait_pos(10);
        digits_in = 16'h0009;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        run(40);

        // Load on the exact boundary cycle
        wait_pos(15);
        digits_in = 16'h4321;
        dp_in     = 4'b0001;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk("bnd_slot0_seg", seg, 8'b1001_1110);
        run(20);

        // Enable dropped mid-slot 2, scan resumes where it stopped
        wait_pos(10);
        enable = 1'b0;
        run(10);
        chk("dis_an", {4'h0, an}, 8'h0F);
        enable = 1'b1;
        cycle();
        chk("resume_an0", {4'h0, an}, 8'b0000_1011);
        cycle();
        chk("resume_an1", {4'h0, an}, 8'b0000_1011);
        cycle();
        chk("resume_an2", {4'h0, an}, 8'b0000_0111);
        run(20);

        // Reset with a pending load discards it
        wait_pos(4);
        digits_in = 16'h5555;
        dp_in     = 4'hF;
        load      = 1'b1;
        cycle();
        load = 1'b0;
        run(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(40);
        chk("post_rst_seg", seg, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
